// File: rtl/slave_to_master_mux.sv
// AHB response-path multiplexer: routes HRDATA/HREADY/HRESP from the slave that
// owns the data phase and hosts the default slave that errors unmapped transfers.
module slave_to_master_mux #(
    parameter int NUM_SLAVES  = 4,
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 32,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                                  Hclk,
    input  logic                                  Hrst,
    input  logic [NUM_SLAVES-1:0]                 Hsel,
    input  logic [1:0]                            Htrans,
    input  logic [MW-1:0]                         Hmaster,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] Hrdata_S,
    input  logic [NUM_SLAVES-1:0]                 Hreadyout_S,
    input  logic [NUM_SLAVES-1:0]                 Hresp_S,
    output logic [DATA_WIDTH-1:0]                 Hrdata,
    output logic                                  Hready,
    output logic                                  Hresp,
    output logic [MW-1:0]                         Hmaster_data,
    output logic                                  Hdata_active
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    ds_state_e       state_q, state_d;
    logic [SW-1:0]   sel_idx_q, sel_idx_d;
    logic            sel_v_q, sel_v_d;
    logic [MW-1:0]   master_q, master_d;

    logic [DATA_WIDTH-1:0] hrdata_s;
    logic                  hready_s;
    logic                  hresp_s;
    logic                  accept_s;
    logic                  trans_active_s;
    logic                  unmapped_s;

    // Encodes a select vector; scanning downward lets the lowest set bit win.
    function automatic logic [SW-1:0] lowest_index(input logic [NUM_SLAVES-1:0] v);
        logic [SW-1:0] idx;
        idx = {SW{1'b0}};
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Response selection: real slave when one owns the data phase, else default slave.
    always_comb begin
        hrdata_s = {DATA_WIDTH{1'b0}};
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        if (sel_v_q) begin
            hrdata_s = Hrdata_S[sel_idx_q];
            hready_s = Hreadyout_S[sel_idx_q];
            hresp_s  = Hresp_S[sel_idx_q];
        end else begin
            case (state_q)
                DS_IDLE: begin
                    hready_s = 1'b1;
                    hresp_s  = 1'b0;
                end
                DS_ERR1: begin
                    hready_s = 1'b0;
                    hresp_s  = 1'b1;
                end
                DS_ERR2: begin
                    hready_s = 1'b1;
                    hresp_s  = 1'b1;
                end
                default: begin
                    hready_s = 1'b1;
                    hresp_s  = 1'b0;
                end
            endcase
        end
    end

    assign accept_s       = hready_s;
    assign trans_active_s = (Htrans == 2'b10) || (Htrans == 2'b11);
    assign unmapped_s     = (Hsel == {NUM_SLAVES{1'b0}});

    // Next-state: address-phase registers move only on acceptance; ERR1 always moves on.
    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        sel_v_d   = sel_v_q;
        master_d  = master_q;
        if (accept_s) begin
            sel_idx_d = lowest_index(Hsel);
            sel_v_d   = |Hsel;
            master_d  = Hmaster;
        end else begin
            sel_idx_d = sel_idx_q;
            sel_v_d   = sel_v_q;
            master_d  = master_q;
        end
        case (state_q)
            DS_ERR1: begin
                state_d = DS_ERR2;
            end
            DS_IDLE, DS_ERR2: begin
                if (accept_s) begin
                    if (unmapped_s && trans_active_s) begin
                        state_d = DS_ERR1;
                    end else begin
                        state_d = DS_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // State and data-phase registers with synchronous reset.
    always_ff @(posedge Hclk) begin
        if (Hrst) begin
            state_q   <= DS_IDLE;
            sel_idx_q <= {SW{1'b0}};
            sel_v_q   <= 1'b0;
            master_q  <= {MW{1'b0}};
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            sel_v_q   <= sel_v_d;
            master_q  <= master_d;
        end
    end

    assign Hrdata       = hrdata_s;
    assign Hready       = hready_s;
    assign Hresp        = hresp_s;
    assign Hmaster_data = master_q;
    assign Hdata_active = sel_v_q | (state_q != DS_IDLE);

endmodule

// File: tb/tb_slave_to_master_mux.sv
// Bench for slave_to_master_mux: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the response path.
module tb_slave_to_master_mux;

    logic             Hclk;
    logic             Hrst;
    logic [3:0]       Hsel;
    logic [1:0]       Htrans;
    logic [1:0]       Hmaster;
    logic [3:0][31:0] Hrdata_S;
    logic [3:0]       Hreadyout_S;
    logic [3:0]       Hresp_S;
    logic [31:0]      Hrdata;
    logic             Hready;
    logic             Hresp;
    logic [1:0]       Hmaster_data;
    logic             Hdata_active;

    int checks = 0;
    int errors = 0;

    // Model: who owns the data phase and how many default-slave error cycles remain.
    bit         m_valid = 1'b0;
    bit         m_sel_v;
    int         m_idx;
    logic [1:0] m_master;
    int         m_err_left;

    slave_to_master_mux #(.NUM_SLAVES(4), .NUM_MASTERS(4), .DATA_WIDTH(32)) dut (
        .Hclk(Hclk), .Hrst(Hrst), .Hsel(Hsel), .Htrans(Htrans), .Hmaster(Hmaster),
        .Hrdata_S(Hrdata_S), .Hreadyout_S(Hreadyout_S), .Hresp_S(Hresp_S),
        .Hrdata(Hrdata), .Hready(Hready), .Hresp(Hresp),
        .Hmaster_data(Hmaster_data), .Hdata_active(Hdata_active)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (m_sel_v) return Hreadyout_S[m_idx];
        return (m_err_left != 2);
    endfunction

    // Model update at each rising edge from the inputs presented in that cycle.
    always @(posedge Hclk) begin
        if (Hrst) begin
            m_valid    = 1'b1;
            m_sel_v    = 1'b0;
            m_idx      = 0;
            m_master   = 2'd0;
            m_err_left = 0;
        end else if (m_valid) begin
            if (model_ready()) begin
                m_sel_v  = (Hsel != 4'd0);
                m_master = Hmaster;
                m_idx    = 0;
                for (int i = 0; i < 4; i++) begin
                    if (Hsel[i]) begin
                        m_idx = i;
                        break;
                    end
                end
                m_err_left = (Hsel == 4'd0 && Htrans[1]) ? 2 : 0;
            end else if (m_err_left == 2) begin
                m_err_left = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Hclk) begin
        if (m_valid) begin
            if (m_sel_v) begin
                check("model_hrdata", Hrdata, Hrdata_S[m_idx]);
                check("model_hresp", {31'd0, Hresp}, {31'd0, Hresp_S[m_idx]});
            end else begin
                check("model_hrdata", Hrdata, 32'd0);
                check("model_hresp", {31'd0, Hresp}, {31'd0, (m_err_left != 0)});
            end
            check("model_hready", {31'd0, Hready}, {31'd0, model_ready()});
            check("model_hmaster_data", {30'd0, Hmaster_data}, {30'd0, m_master});
            check("model_hdata_active", {31'd0, Hdata_active},
                  {31'd0, (m_sel_v || m_err_left != 0)});
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic expect_resp(input string name, input logic r, input logic e, input logic act);
        @(negedge Hclk);
        check({name, "_hready"}, {31'd0, Hready}, {31'd0, r});
        check({name, "_hresp"}, {31'd0, Hresp}, {31'd0, e});
        check({name, "_active"}, {31'd0, Hdata_active}, {31'd0, act});
    endtask

    initial begin
        Hrst = 1'b1; Hsel = 4'd0; Htrans = 2'b00; Hmaster = 2'd0;
        Hrdata_S = '0; Hreadyout_S = 4'd0; Hresp_S = 4'd0;
        tick();
        tick();
        Hrst = 1'b0;
        expect_resp("reset", 1'b1, 1'b0, 1'b0);
        check("reset_hrdata", Hrdata, 32'd0);
        check("reset_hmaster_data", {30'd0, Hmaster_data}, 32'd0);

        // Mapped read with two wait states; address changes during the wait are ignored.
        tick();
        Hmaster = 2'd2; Hsel = 4'b0100; Htrans = 2'b10;
        Hrdata_S[2] = 32'hCAFE_F00D; Hreadyout_S = 4'b0000;
        tick();
        Hsel = 4'b1000; Hmaster = 2'd3; Htrans = 2'b10;
        expect_resp("wait1", 1'b0, 1'b0, 1'b1);
        check("wait1_hmaster_data", {30'd0, Hmaster_data}, 32'd2);
        tick();
        expect_resp("wait2", 1'b0, 1'b0, 1'b1);
        check("wait2_hrdata", Hrdata, 32'hCAFE_F00D);
        tick();
        Hreadyout_S = 4'b0100; Hsel = 4'd0; Htrans = 2'b00;
        expect_resp("rdone", 1'b1, 1'b0, 1'b1);
        check("rdone_hrdata", Hrdata, 32'hCAFE_F00D);
        check("rdone_hmaster_data", {30'd0, Hmaster_data}, 32'd2);

        // Idle unmapped gives zero-wait OKAY; then a single unmapped NONSEQ.
        tick();
        Htrans = 2'b10;
        expect_resp("idle_unmapped", 1'b1, 1'b0, 1'b0);
        tick();
        Htrans = 2'b00;
        expect_resp("err1", 1'b0, 1'b1, 1'b1);
        check("err1_hrdata", Hrdata, 32'd0);
        tick();
        expect_resp("err2", 1'b1, 1'b1, 1'b1);
        tick();
        expect_resp("after_err", 1'b1, 1'b0, 1'b0);

        // Back-to-back unmapped NONSEQ, then slave 0.
        Htrans = 2'b10;
        tick();
        expect_resp("b2b_err1a", 1'b0, 1'b1, 1'b1);
        tick();
        expect_resp("b2b_err2a", 1'b1, 1'b1, 1'b1);
        tick();
        Hsel = 4'b0001; Hrdata_S[0] = 32'h1234_5678; Hreadyout_S = 4'b1111;
        expect_resp("b2b_err1b", 1'b0, 1'b1, 1'b1);
        tick();
        expect_resp("b2b_err2b", 1'b1, 1'b1, 1'b1);
        tick();
        Hsel = 4'd0; Htrans = 2'b10;
        expect_resp("slave0", 1'b1, 1'b0, 1'b1);
        check("slave0_hrdata", Hrdata, 32'h1234_5678);

        // Reset during ERR1, then multi-hot select routes the lowest slave.
        tick();
        Hrst = 1'b1; Hsel = 4'b0110; Hmaster = 2'd1;
        expect_resp("rst_err1", 1'b0, 1'b1, 1'b1);
        tick();
        Hrst = 1'b0;
        Hrdata_S[1] = 32'hB0B0_1111; Hrdata_S[2] = 32'hDEAD_2222; Hresp_S = 4'b0000;
        expect_resp("rst_abort", 1'b1, 1'b0, 1'b0);
        tick();
        Hsel = 4'd0; Htrans = 2'b00;
        expect_resp("multihot", 1'b1, 1'b0, 1'b1);
        check("multihot_hrdata", Hrdata, 32'hB0B0_1111);
        check("multihot_hmaster_data", {30'd0, Hmaster_data}, 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            Hrst    = ($urandom_range(0, 99) == 0);
            Hsel    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            Htrans  = 2'($urandom_range(0, 3));
            Hmaster = 2'($urandom_range(0, 3));
            for (int s = 0; s < 4; s++) begin
                Hrdata_S[s]    = $urandom;
                Hreadyout_S[s] = ($urandom_range(0, 3) != 0);
                Hresp_S[s]     = ($urandom_range(0, 4) == 0);
            end
        end
        tick();
        Hrst = 1'b0;
        @(negedge Hclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_to_master_mux.md
Name: slave_to_master_mux

Overview:
Response-path multiplexer for the AHB interconnect. It returns HRDATA, HREADY and HRESP from the addressed slave back to the masters. The block registers the decoder's one-hot slave select and the granted master index at address-phase acceptance, so the data phase is routed from the correct slave and tagged with the correct master. It also contains the default slave, which answers unmapped transfers with the two-cycle AHB ERROR response.

Parameters:
NUM_SLAVES, 4, number of slave ports; index width is $clog2(NUM_SLAVES).
NUM_MASTERS, 4, number of masters; Hmaster index is 2 bits wide.
DATA_WIDTH, 32, read data width.

Ports:
Hclk  input  1  bus clock; all state updates on the rising edge.
Hrst  input  1  synchronous, active-high reset.
Hsel  input  NUM_SLAVES  one-hot address-phase slave select from the decoder.
Htrans  input  2  address-phase transfer type of the granted master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
Hmaster  input  2  address-phase granted master index from the arbiter.
Hrdata_S  input  DATA_WIDTH x NUM_SLAVES  per-slave read data.
Hreadyout_S  input  1 x NUM_SLAVES  per-slave HREADYOUT.
Hresp_S  input  1 x NUM_SLAVES  per-slave HRESP (0 OKAY, 1 ERROR).
Hrdata  output  DATA_WIDTH  read data to the masters.
Hready  output  1  bus HREADY; broadcast to all masters and slaves.
Hresp  output  1  bus HRESP.
Hmaster_data  output  2  master index owning the current data phase; drives the write-data mux select.
Hdata_active  output  1  high while a data phase owned by a real slave or by the default slave is in progress.

Behaviour:
- An address phase is accepted on any rising edge where Hready=1. Only on acceptance do the following registers update:
  - sel_d: encoded index of Hsel. If Hsel is multi-hot, the lowest set bit wins.
  - sel_v: set to |Hsel.
  - Hmaster_data: set to Hmaster.
  - Default-slave FSM: see below.
- Real-slave data phase (sel_v=1):
  - Hrdata = Hrdata_S[sel_d], Hready = Hreadyout_S[sel_d], Hresp = Hresp_S[sel_d].
  - All three are purely combinational from the registered select; there is no added latency.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2. Evaluated only on acceptance, except where noted:
  - Hsel==0 and Htrans is NONSEQ or SEQ: go to DS_ERR1.
  - Hsel==0 and Htrans is IDLE or BUSY: stay in or go to DS_IDLE (zero-wait OKAY).
  - Any Hsel bit set: go to DS_IDLE.
  - DS_ERR1 always advances to DS_ERR2 on the next edge, independent of Hready.
  - DS_ERR1 outputs: Hready=0, Hresp=1.
  - DS_ERR2 outputs: Hready=1, Hresp=1. Because Hready=1, a new address phase is accepted here and the next state follows the acceptance rules.
- Outputs when sel_v=0:
  - In DS_IDLE: Hready=1, Hresp=0.
  - In both DS_ERR states: Hrdata=0.
  - In all cases with sel_v=0: Hrdata=0.
- Hdata_active = sel_v | (state != DS_IDLE).
- While Hready=0, sel_d, sel_v, Hmaster_data and Htrans sampling are frozen. Address-phase changes are ignored until acceptance.
- Reset (Hrst=1 at an edge) clears sel_v=0, sel_d=0, Hmaster_data=0 and the FSM to DS_IDLE. From the following cycle: Hready=1, Hresp=0, Hrdata=0, Hdata_active=0.
  - Reset in the middle of a wait-stated or ERROR data phase aborts it immediately; no residual ERROR cycle follows.
- Simultaneous events:
  - Acceptance in DS_ERR2 with a new unmapped NONSEQ returns to DS_ERR1, giving back-to-back error responses.
  - Acceptance while a slave drives Hreadyout_S=1 with Hresp_S=1 (second ERROR cycle) switches select on that edge as normal.
- Hresp from a slave is passed through unchanged; this block performs no two-cycle checking on slave responses.

Test Plan:
- Reset: hold Hrst=1 for 2 cycles with Hreadyout_S all 0 -> Hready=1, Hresp=0, Hrdata=0, Hmaster_data=0, Hdata_active=0.
- Mapped read: Hmaster=2, Hsel=4'b0100, Htrans=NONSEQ accepted; slave 2 drives Hrdata_S=32'hCAFE_F00D with Hreadyout_S=0 for 2 cycles then 1 -> Hready is 0,0,1; Hrdata=32'hCAFE_F00D; Hmaster_data=2 throughout; Hsel changes during the wait are ignored.
- Unmapped access: Hsel=0, Htrans=NONSEQ accepted -> next cycle Hready=0/Hresp=1, then Hready=1/Hresp=1, then Hready=1/Hresp=0 with Htrans=IDLE.
- Idle unmapped: Hsel=0, Htrans=IDLE -> Hready stays 1, Hresp stays 0, Hdata_active=0.
- Back-to-back: unmapped NONSEQ, then a new unmapped NONSEQ presented in DS_ERR2 -> response sequence is ERR1, ERR2, ERR1, ERR2; then Hsel=4'b0001 gives slave 0 data next.
- Reset mid-ERROR: assert Hrst during DS_ERR1 -> next cycle Hready=1, Hresp=0, FSM in DS_IDLE; multi-hot Hsel=4'b0110 routes slave 1.
